// File: rtl/led_fade_ctrl_if.sv
// rtl/led_fade_ctrl_if.sv - button/mode inputs and duty/direction outputs of the LED fade controller
interface led_fade_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       mode;
  logic [7:0] p;
  logic       dir;

  modport master (output btn_up, output btn_down, output mode, input p, input dir);
  modport slave  (input btn_up, input btn_down, input mode, output p, output dir);
endinterface

// File: rtl/led_fade_ctrl.sv
// rtl/led_fade_ctrl.sv - duty word source: debounced manual stepping or triangle breathing ramp
module led_fade_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int STEP       = 16,
  parameter int TICK_DIV   = 195312
) (
  input  logic         CLK,
  input  logic         RSTN,
  led_fade_ctrl_if.slave io
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // bit 0 = up, bit 1 = down, bit 2 = mode
  logic [2:0]          s1_q, s1_d, s2_q, s2_d;
  logic [1:0]          deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [1:0][DW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [7:0]          p_q, p_d;
  logic                dir_q, dir_d;

  logic [1:0] pulse;
  logic       mode_s;
  logic       tick;
  logic [8:0] sum9, diff9;

  assign mode_s = s2_q[2];
  assign pulse  = deb_q & ~deb_dly_q;
  assign sum9   = {1'b0, p_q} + 9'(STEP);
  assign diff9  = {1'b0, p_q} - 9'(STEP);

  always_comb begin
    s1_d      = {io.mode, io.btn_down, io.btn_up};
    s2_d      = s1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = '0;
    p_d        = p_q;
    dir_d      = dir_q;
    if (mode_s) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      // Endpoints bounce straight to the neighbour so each is held for one tick only
      if (tick) begin
        if (dir_q) begin
          if (p_q == 8'hFF) begin
            p_d   = 8'hFE;
            dir_d = 1'b0;
          end else begin
            p_d = p_q + 8'd1;
          end
        end else begin
          if (p_q == 8'h00) begin
            p_d   = 8'h01;
            dir_d = 1'b1;
          end else begin
            p_d = p_q - 8'd1;
          end
        end
      end
    end else begin
      case (pulse)
        2'b01:   p_d = sum9[8] ? 8'hFF : sum9[7:0];
        2'b10:   p_d = diff9[8] ? 8'h00 : diff9[7:0];
        default: p_d = p_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      cnt_q      <= '0;
      tick_cnt_q <= '0;
      p_q        <= '0;
      dir_q      <= 1'b1;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      p_q        <= p_d;
      dir_q      <= dir_d;
    end
  end

  assign io.p   = p_q;
  assign io.dir = dir_q;
endmodule

// File: tb/tb_led_fade_ctrl.sv
// tb/tb_led_fade_ctrl.sv - directed vector bench for led_fade_ctrl
module tb_led_fade_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] m_p;
  logic       m_dir;

  typedef struct {
    logic       up;
    logic       down;
    int         hold;
    logic [7:0] exp_p;
  } vec_t;
  vec_t tbl[$];

  led_fade_ctrl_if bus ();

  led_fade_ctrl #(.DEB_CYCLES(4), .STEP(16), .TICK_DIV(3)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .io   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic up, input logic down, input int hold);
    @(negedge clk);
    bus.btn_up   = up;
    bus.btn_down = down;
    repeat (hold) @(negedge clk);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_change(output bit ok, output int edges);
    logic [7:0] pp;
    logic       pd;
    pp = bus.p;
    pd = bus.dir;
    ok = 1'b0;
    edges = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.p != pp || bus.dir != pd) ok = 1'b1;
    end
  endtask

  task automatic breath_until(input logic [7:0] tp, input logic td, input bit fresh);
    bit ok;
    int edges;
    bit first;
    int guard;
    first = fresh;
    guard = 0;
    do begin
      wait_change(ok, edges);
      check("tick_seen", int'(ok), 1);
      if (!ok) return;
      if (m_dir) begin
        if (m_p == 8'hFF) begin m_p = 8'hFE; m_dir = 1'b0; end
        else m_p = m_p + 8'd1;
      end else begin
        if (m_p == 8'h00) begin m_p = 8'h01; m_dir = 1'b1; end
        else m_p = m_p - 8'd1;
      end
      check("ramp_p", bus.p, m_p);
      check("ramp_dir", bus.dir, m_dir);
      if (!first) check("tick_period", edges, 3);
      first = 1'b0;
      guard++;
    end while (!(m_p == tp && m_dir == td) && guard < 1200);
  endtask

  initial begin
    int pv;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.mode     = 1'b0;

    pv = 16;
    for (int k = 0; k < 16; k++) begin
      pv = (pv + 16 > 255) ? 255 : pv + 16;
      tbl.push_back('{1'b1, 1'b0, 10, 8'(pv)});
    end
    for (int k = 0; k < 20; k++) begin
      pv = (pv - 16 < 0) ? 0 : pv - 16;
      tbl.push_back('{1'b0, 1'b1, 10, 8'(pv)});
    end
    tbl.push_back('{1'b1, 1'b0, 3, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 3, 8'd0});

    repeat (3) @(negedge clk);
    check("reset_p", bus.p, 0);
    check("reset_dir", bus.dir, 1);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_p", bus.p, 0);

    // First press: p must still be 0 after edge 5 and be 16 by edge 7
    bus.btn_up = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) check("press_early", bus.p, 0);
      if (e == 7) check("press_latency", bus.p, 16);
    end
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check("press_held", bus.p, 16);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].up, tbl[i].down, tbl[i].hold);
      check($sformatf("vec%0d_p", i), bus.p, tbl[i].exp_p);
    end

    @(negedge clk);
    for (int b = 0; b < 6; b++) begin
      bus.btn_up = ~bus.btn_up;
      @(negedge clk);
    end
    bus.btn_up = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_p", bus.p, 16);

    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    repeat (10) @(negedge clk);
    check("both_p", bus.p, 16);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check("up_release_p", bus.p, 16);
    bus.btn_up = 1'b1;
    repeat (10) @(negedge clk);
    check("repress_up_p", bus.p, 32);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (12) @(negedge clk);

    m_p   = 8'd32;
    m_dir = 1'b1;
    bus.mode   = 1'b1;
    bus.btn_up = 1'b1;
    breath_until(8'd255, 1'b1, 1'b1);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b1;
    breath_until(8'd253, 1'b0, 1'b0);
    bus.btn_down = 1'b0;
    breath_until(8'd1, 1'b1, 1'b0);
    breath_until(8'd200, 1'b0, 1'b0);
    bus.mode = 1'b0;
    repeat (10) @(negedge clk);
    check("freeze_p", bus.p, 200);
    check("freeze_dir", bus.dir, 0);
    apply(1'b1, 1'b0, 10);
    check("manual_after_ramp_p", bus.p, 216);
    check("manual_after_ramp_dir", bus.dir, 0);
    m_p = 8'd216;
    bus.mode = 1'b1;
    breath_until(8'd215, 1'b0, 1'b1);
    breath_until(8'd100, 1'b0, 1'b0);

    #1;
    rstn = 1'b0;
    #1;
    check("async_reset_p", bus.p, 0);
    check("async_reset_dir", bus.dir, 1);
    bus.mode = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_p", bus.p, 0);
    check("post_reset_dir", bus.dir, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
